// File: rtl/leitor_historico_memoria.sv
// Ring history of committed ALU results with indexed recall (index 0 = newest).
// Optional LEITOR_HISTORICO_PROTECAO_EN: reject stores when full and pulse erro_escrita.
module leitor_historico_memoria #(
    parameter int unsigned LARGURA      = 8,
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned IW           = $clog2(PROFUNDIDADE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gravar,
    input  logic [LARGURA-1:0] resultado_entrada,
    input  logic               limpar,
    input  logic               ler_req,
    input  logic [IW-1:0]      ler_indice,
    input  logic               ler_ack,
    output logic [LARGURA-1:0] operando_saida,
    output logic               operando_valido,
    output logic               erro_leitura,
    output logic               ocupado,
    output logic [IW:0]        contagem,
    output logic               vazio,
`ifdef LEITOR_HISTORICO_PROTECAO_EN
    output logic               erro_escrita,
`endif
    output logic               cheio
);

    localparam logic [IW:0] CONTAGEM_MAX = (IW+1)'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t            estado;
    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [IW-1:0]      wptr;
    logic [IW-1:0]      wptr_nxt;
    logic [IW:0]        contagem_nxt;
    logic [IW-1:0]      indice_lat;
    logic [IW-1:0]      end_leitura;
    logic               cheio_int;
    logic               grava_ok;

    // Write acceptance and next pointer/count; limpar overrides any store.
    always_comb begin
        cheio_int = (contagem == CONTAGEM_MAX);
`ifdef LEITOR_HISTORICO_PROTECAO_EN
        grava_ok  = gravar && !limpar && !cheio_int;
`else
        grava_ok  = gravar && !limpar;
`endif
        wptr_nxt     = wptr;
        contagem_nxt = contagem;
        if (limpar) begin
            wptr_nxt     = '0;
            contagem_nxt = '0;
        end else if (grava_ok) begin
            wptr_nxt = wptr + IW'(1);
            if (!cheio_int) begin
                contagem_nxt = contagem + (IW+1)'(1);
            end
        end
    end

    // Entry k sits k slots behind the newest; IW-bit arithmetic wraps the ring.
    assign end_leitura = wptr - IW'(1) - indice_lat;

    always_ff @(posedge clk) begin
        if (grava_ok) begin
            mem[wptr] <= resultado_entrada;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            contagem <= '0;
            vazio    <= 1'b1;
            cheio    <= 1'b0;
        end else begin
            wptr     <= wptr_nxt;
            contagem <= contagem_nxt;
            vazio    <= (contagem_nxt == '0);
            cheio    <= (contagem_nxt == CONTAGEM_MAX);
        end
    end

`ifdef LEITOR_HISTORICO_PROTECAO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            erro_escrita <= 1'b0;
        end else begin
            erro_escrita <= gravar && !limpar && cheio_int;
        end
    end
`endif

    // Recall FSM; the BUSCA lookup sees the array before any same-cycle store.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado          <= OCIOSO;
            indice_lat      <= '0;
            operando_saida  <= '0;
            operando_valido <= 1'b0;
            erro_leitura    <= 1'b0;
            ocupado         <= 1'b0;
        end else begin
            erro_leitura <= 1'b0;
            if (limpar) begin
                estado          <= OCIOSO;
                operando_valido <= 1'b0;
                ocupado         <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (ler_req) begin
                            indice_lat <= ler_indice;
                            estado     <= BUSCA;
                            ocupado    <= 1'b1;
                        end
                    end
                    BUSCA: begin
                        if ({1'b0, indice_lat} < contagem) begin
                            operando_saida  <= mem[end_leitura];
                            operando_valido <= 1'b1;
                            estado          <= ENTREGA;
                        end else begin
                            operando_saida <= '0;
                            erro_leitura   <= 1'b1;
                            estado         <= OCIOSO;
                            ocupado        <= 1'b0;
                        end
                    end
                    ENTREGA: begin
                        if (ler_ack) begin
                            operando_valido <= 1'b0;
                            estado          <= OCIOSO;
                            ocupado         <= 1'b0;
                        end
                    end
                    default: begin
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_leitor_historico_memoria.sv
// Directed bench for leitor_historico_memoria (PROFUNDIDADE=4, LARGURA=8).
// Covers LEITOR_HISTORICO_PROTECAO_EN when the macro is defined for both files.
module tb_leitor_historico_memoria;

    logic       clk;
    logic       rst;
    logic       gravar;
    logic [7:0] resultado_entrada;
    logic       limpar;
    logic       ler_req;
    logic [1:0] ler_indice;
    logic       ler_ack;
    logic [7:0] operando_saida;
    logic       operando_valido;
    logic       erro_leitura;
    logic       ocupado;
    logic [2:0] contagem;
    logic       vazio;
    logic       cheio;
`ifdef LEITOR_HISTORICO_PROTECAO_EN
    logic       erro_escrita;
`endif

    int checks = 0;
    int erros  = 0;

    leitor_historico_memoria #(.LARGURA(8), .PROFUNDIDADE(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .gravar            (gravar),
        .resultado_entrada (resultado_entrada),
        .limpar            (limpar),
        .ler_req           (ler_req),
        .ler_indice        (ler_indice),
        .ler_ack           (ler_ack),
        .operando_saida    (operando_saida),
        .operando_valido   (operando_valido),
        .erro_leitura      (erro_leitura),
        .ocupado           (ocupado),
        .contagem          (contagem),
        .vazio             (vazio),
`ifdef LEITOR_HISTORICO_PROTECAO_EN
        .erro_escrita      (erro_escrita),
`endif
        .cheio             (cheio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grava(input logic [7:0] v);
        gravar = 1'b1;
        resultado_entrada = v;
        tick();
        gravar = 1'b0;
    endtask

    task automatic limpa();
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
    endtask

    // Successful recall: valid appears two edges after the request is presented.
    task automatic ler_ok(input string tag, input logic [1:0] idx, input logic [7:0] esp);
        ler_req = 1'b1;
        ler_indice = idx;
        tick();
        ler_req = 1'b0;
        verificar({tag, "_valido_cedo"}, 32'(operando_valido), 32'(0));
        verificar({tag, "_ocupado"}, 32'(ocupado), 32'(1));
        tick();
        verificar({tag, "_valido"}, 32'(operando_valido), 32'(1));
        verificar({tag, "_dado"}, 32'(operando_saida), 32'(esp));
        ler_ack = 1'b1;
        tick();
        ler_ack = 1'b0;
        verificar({tag, "_valido_ack"}, 32'(operando_valido), 32'(0));
        verificar({tag, "_livre"}, 32'(ocupado), 32'(0));
    endtask

    // Out-of-range recall: one-cycle error pulse, output forced to zero.
    task automatic ler_erro(input string tag, input logic [1:0] idx);
        ler_req = 1'b1;
        ler_indice = idx;
        tick();
        ler_req = 1'b0;
        tick();
        verificar({tag, "_erro"}, 32'(erro_leitura), 32'(1));
        verificar({tag, "_dado0"}, 32'(operando_saida), 32'(0));
        verificar({tag, "_valido"}, 32'(operando_valido), 32'(0));
        verificar({tag, "_livre"}, 32'(ocupado), 32'(0));
        tick();
        verificar({tag, "_erro_pulso"}, 32'(erro_leitura), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        gravar = 1'b0;
        resultado_entrada = 8'h00;
        limpar = 1'b0;
        ler_req = 1'b0;
        ler_indice = 2'd0;
        ler_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        verificar("rst_contagem", 32'(contagem), 32'(0));
        verificar("rst_vazio", 32'(vazio), 32'(1));
        verificar("rst_cheio", 32'(cheio), 32'(0));
        verificar("rst_valido", 32'(operando_valido), 32'(0));
        verificar("rst_saida", 32'(operando_saida), 32'(0));
        verificar("rst_erro", 32'(erro_leitura), 32'(0));
        verificar("rst_ocupado", 32'(ocupado), 32'(0));

        // Three stores, then recall newest and oldest
        grava(8'h11);
        grava(8'h22);
        grava(8'h33);
        verificar("t1_contagem", 32'(contagem), 32'(3));
        verificar("t1_vazio", 32'(vazio), 32'(0));
        verificar("t1_cheio", 32'(cheio), 32'(0));
        ler_ok("t1_idx0", 2'd0, 8'h33);
        ler_ok("t1_idx2", 2'd2, 8'h11);

        // Wrap: five stores into four slots
        limpa();
        verificar("t2_limpo", 32'(contagem), 32'(0));
        for (int i = 1; i <= 5; i++) grava(8'(i));
`ifdef LEITOR_HISTORICO_PROTECAO_EN
        verificar("t2_contagem", 32'(contagem), 32'(4));
        verificar("t2_cheio", 32'(cheio), 32'(1));
        ler_ok("t2_idx0", 2'd0, 8'h04);
        ler_ok("t2_idx3", 2'd3, 8'h01);
`else
        verificar("t2_contagem", 32'(contagem), 32'(4));
        verificar("t2_cheio", 32'(cheio), 32'(1));
        ler_ok("t2_idx0", 2'd0, 8'h05);
        ler_ok("t2_idx3", 2'd3, 8'h02);
        ler_ok("t2_idx1", 2'd1, 8'h04);
`endif

        // Index beyond contagem, including index == contagem
        limpa();
        grava(8'h11);
        grava(8'h22);
        ler_erro("t3_idx3", 2'd3);
        ler_erro("t3_idx2", 2'd2);
        ler_ok("t3_idx1", 2'd1, 8'h11);

        // Held output survives a store and a delayed ack
        limpa();
        grava(8'h11);
        grava(8'h22);
        grava(8'h33);
        ler_req = 1'b1;
        ler_indice = 2'd0;
        tick();
        ler_req = 1'b0;
        tick();
        verificar("t4_dado", 32'(operando_saida), 32'(8'h33));
        grava(8'h44);
        for (int i = 0; i < 3; i++) begin
            verificar("t4_hold_dado", 32'(operando_saida), 32'(8'h33));
            verificar("t4_hold_valido", 32'(operando_valido), 32'(1));
            if (i < 2) tick();
        end
        ler_ack = 1'b1;
        tick();
        ler_ack = 1'b0;
        verificar("t4_valido_ack", 32'(operando_valido), 32'(0));
        verificar("t4_contagem", 32'(contagem), 32'(4));
        ler_ok("t4_novo", 2'd0, 8'h44);

        // limpar during BUSCA beats a same-cycle store
        ler_req = 1'b1;
        ler_indice = 2'd0;
        tick();
        ler_req = 1'b0;
        limpar = 1'b1;
        gravar = 1'b1;
        resultado_entrada = 8'h55;
        tick();
        limpar = 1'b0;
        gravar = 1'b0;
        verificar("t5_contagem", 32'(contagem), 32'(0));
        verificar("t5_vazio", 32'(vazio), 32'(1));
        verificar("t5_valido", 32'(operando_valido), 32'(0));
        verificar("t5_erro", 32'(erro_leitura), 32'(0));
        verificar("t5_ocupado", 32'(ocupado), 32'(0));
        tick();
        verificar("t5_erro_depois", 32'(erro_leitura), 32'(0));
        ler_erro("t5_idx0", 2'd0);

        // rst mid-read behaves as power-on
        grava(8'h77);
        ler_req = 1'b1;
        ler_indice = 2'd0;
        tick();
        ler_req = 1'b0;
        tick();
        verificar("t6_valido", 32'(operando_valido), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        verificar("t6_rst_valido", 32'(operando_valido), 32'(0));
        verificar("t6_rst_saida", 32'(operando_saida), 32'(0));
        verificar("t6_rst_contagem", 32'(contagem), 32'(0));
        verificar("t6_rst_ocupado", 32'(ocupado), 32'(0));

`ifdef LEITOR_HISTORICO_PROTECAO_EN
        // Store while full is rejected
        for (int i = 0; i < 4; i++) grava(8'(8'hA0 + i));
        verificar("t7_ee_inicial", 32'(erro_escrita), 32'(0));
        grava(8'hFF);
        verificar("t7_ee_pulso", 32'(erro_escrita), 32'(1));
        verificar("t7_contagem", 32'(contagem), 32'(4));
        tick();
        verificar("t7_ee_fim", 32'(erro_escrita), 32'(0));
        ler_ok("t7_idx0", 2'd0, 8'hA3);
        ler_ok("t7_idx3", 2'd3, 8'hA0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, erros);
        $finish;
    end

endmodule

// File: doc/leitor_historico_memoria.md
Name: leitor_historico_memoria

Overview:
- Read side of the result memory. Captures every ALU result committed with the store strobe into a small ring of past results.
- Serves recall requests from the operand-select path over a req/valid/ack handshake. Index 0 is the most recent result.
- Sits between the ALU result bus and the operand B mux. Replaces direct single-value recall with a multi-entry history.

Parameters:
- LARGURA, 8, data width of a stored result.
- PROFUNDIDADE, 4, number of history entries. Must be a power of 2 and at least 2.
- IW, $clog2(PROFUNDIDADE), width of the index and pointer fields. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- gravar  input  1  store strobe; captures resultado_entrada this cycle.
- resultado_entrada  input  LARGURA  ALU result to store.
- limpar  input  1  synchronous history clear (memory-clear key).
- ler_req  input  1  recall request; sampled only in OCIOSO.
- ler_indice  input  IW  age of the entry requested; 0 = newest.
- ler_ack  input  1  consumer accepts operando_saida.
- operando_saida  output  LARGURA  recalled value.
- operando_valido  output  1  operando_saida holds a valid recalled value.
- erro_leitura  output  1  one-cycle pulse: requested index ≥ contagem.
- ocupado  output  1  high whenever the FSM is not in OCIOSO.
- contagem  output  IW+1  number of valid entries, 0..PROFUNDIDADE.
- vazio  output  1  contagem == 0.
- cheio  output  1  contagem == PROFUNDIDADE.

Behaviour:
- Reset (rst=1 at an edge): state OCIOSO, write pointer 0, contagem 0, operando_saida 0, operando_valido 0, erro_leitura 0. Storage array contents are don't-care.
- Write: gravar=1 stores resultado_entrada at the write pointer. The pointer advances mod PROFUNDIDADE. contagem increments, saturating at PROFUNDIDADE.
- Write when full: the oldest entry is overwritten; contagem stays at PROFUNDIDADE.
- Entry address: entry k lives at (wptr − 1 − k) mod PROFUNDIDADE. The wrap-around is implicit in the IW-bit subtraction.
- FSM states:
  - OCIOSO: if ler_req=1, latch ler_indice and go to BUSCA.
  - BUSCA: one cycle.
    - If the latched index < contagem: load operando_saida from the array and go to ENTREGA.
    - Otherwise: pulse erro_leitura for 1 cycle, force operando_saida to 0, return to OCIOSO.
    - Index and contagem are evaluated against state before any gravar in the same cycle; a write takes effect at the end of the cycle.
  - ENTREGA: operando_valido=1; operando_saida is held stable.
    - On ler_ack=1: clear operando_valido next cycle and return to OCIOSO.
    - Writes during ENTREGA update the array but never the held output.
- Latency: request edge to operando_valido high is 2 cycles. Back-to-back reads need ack, then one OCIOSO cycle, before the next request is accepted.
- ler_req outside OCIOSO is ignored; the requester must hold it until ocupado=0.
- limpar=1:
  - Sets wptr=0 and contagem=0.
  - Drops operando_valido and returns the FSM to OCIOSO next cycle. This aborts an in-flight read; no erro_leitura is raised.
  - Takes priority over a gravar in the same cycle; that write is discarded.
- rst asserted mid-read behaves exactly as power-on reset.
- ler_ack outside ENTREGA has no effect.

Optional Feature:
- Macro: LEITOR_HISTORICO_PROTECAO_EN.
- Defined: gravar while cheio=1 is rejected. The array and pointer are unchanged, and a 1-cycle pulse appears on an added output, erro_escrita (1 bit, reset 0).
- Undefined: overwrite-oldest as above; the erro_escrita port does not exist.

Test Plan:
- Reset, then gravar 0x11, 0x22, 0x33 -> contagem=3, vazio=0, cheio=0. Read index 0 -> operando_saida=0x33, valido 2 cycles after the request edge. Read index 2 -> 0x11.
- Write 0x01..0x05 with PROFUNDIDADE=4 -> cheio=1, contagem=4. Index 0 = 0x05, index 3 = 0x02; 0x01 is lost (wrap).
- Two entries stored, request index 3 -> erro_leitura pulses once, operando_saida=0, operando_valido stays 0, FSM back to OCIOSO.
- In ENTREGA holding 0x33, gravar 0x44 and delay ack 3 cycles -> output stays 0x33 until ack. A new read of index 0 then returns 0x44.
- limpar during BUSCA with gravar 0x55 in the same cycle -> contagem=0, no valid, no error. The next index-0 read raises erro_leitura.
- With LEITOR_HISTORICO_PROTECAO_EN defined: fill with 0xA0..0xA3, then gravar 0xFF -> erro_escrita pulses, index 0 still 0xA3.
